// File: rtl/dp_feat_feeder_if.sv
// dp_feat_feeder_if: front-end coefficient input and DP_main-side replay output bundle
interface dp_feat_feeder_if #(parameter int DW = 32);
  logic signed [DW-1:0] coef_in;
  logic coef_dv_in;
  logic sof_in;
  logic vad_in;
  logic signed [DW-1:0] vec_out;
  logic dv_out;
  logic vad_out;
  logic busy;
  logic overflow;
  modport master (
    output coef_in, coef_dv_in, sof_in, vad_in,
    input vec_out, dv_out, vad_out, busy, overflow
  );
  modport slave (
    input coef_in, coef_dv_in, sof_in, vad_in,
    output vec_out, dv_out, vad_out, busy, overflow
  );
endinterface

// File: rtl/dp_feat_feeder.sv
// dp_feat_feeder: ping-pong frame buffer replaying feature vectors as spaced dv pulses
module dp_feat_feeder #(
  parameter int DW = 32,
  parameter int NCOEF = 12,
  parameter int GAP = 1
) (
  input logic clk,
  input logic reset,
  dp_feat_feeder_if.slave bus
);
  localparam int IW = $clog2(NCOEF);
  localparam logic [IW-1:0] LAST = IW'(NCOEF - 1);
  localparam logic [3:0] GAP_M1 = 4'(GAP == 0 ? 0 : GAP - 1);
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP, S_DONE} state_t;
  state_t state, nxt;
  logic [DW-1:0] mem [2][NCOEF];
  logic [1:0] full, vad_bank, set_vec, clr_vec;
  logic wr_bank, rd_bank, wr_ok, wr_last, rd_last, overflow_q, vad_q, dv, bsy;
  logic [IW-1:0] wr_idx, rd_idx, wr_i, nxt_idx;
  logic [3:0] gap_cnt;
  logic [DW-1:0] vec_q;
  always_comb begin
    wr_i = bus.sof_in ? '0 : wr_idx;
    wr_ok = bus.coef_dv_in && !full[wr_bank];
    wr_last = wr_i == LAST;
    rd_last = rd_idx == LAST;
    nxt_idx = state == S_IDLE ? '0 : rd_idx + 1'b1;
    set_vec = (wr_ok && wr_last) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    clr_vec = state == S_DONE ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_bank][wr_i] <= bus.coef_in;
  // A full bank rejects writes until the reader's DONE edge has passed
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_bank <= 1'b0;
      wr_idx <= '0;
      vad_bank <= '0;
      full <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.coef_dv_in && full[wr_bank]) overflow_q <= 1'b1;
      if (wr_ok) begin
        wr_bank <= wr_bank ^ wr_last;
        wr_idx <= wr_last ? '0 : wr_i + 1'b1;
        if (wr_last) vad_bank[wr_bank] <= bus.vad_in;
      end
      full <= (full | set_vec) & ~clr_vec;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: nxt = full[rd_bank] ? S_EMIT : S_IDLE;
      S_EMIT: nxt = GAP > 0 ? S_GAP : rd_last ? S_DONE : S_EMIT;
      S_GAP: nxt = gap_cnt != GAP_M1 ? S_GAP : rd_last ? S_DONE : S_EMIT;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    dv = state == S_EMIT;
    bsy = state != S_IDLE;
  end
  // rd_idx tracks the coefficient currently presented on vec_out
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_bank <= 1'b0;
      rd_idx <= '0;
      gap_cnt <= '0;
      vec_q <= '0;
      vad_q <= 1'b0;
    end else begin
      gap_cnt <= state == S_GAP ? gap_cnt + 1'b1 : '0;
      if (nxt == S_EMIT) begin
        rd_idx <= nxt_idx;
        vec_q <= mem[rd_bank][nxt_idx];
      end
      if (state == S_IDLE && nxt == S_EMIT) vad_q <= vad_bank[rd_bank];
      if (state == S_DONE) begin
        rd_bank <= ~rd_bank;
        rd_idx <= '0;
      end
    end
  assign bus.vec_out = vec_q;
  assign bus.dv_out = dv;
  assign bus.vad_out = vad_q;
  assign bus.busy = bsy;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_dp_feat_feeder.sv
// tb_dp_feat_feeder: scoreboard plus table-driven frames for GAP=1 and GAP=0 feeders
module tb_dp_feat_feeder;
  localparam int DW = 32;
  localparam int N = 12;
  typedef struct packed {logic [DW-1:0] vec; logic vad;} exp_t;
  typedef struct {logic [DW-1:0] base; bit vad; int partial; logic ovf;} vec_t;
  logic clk = 0;
  logic reset = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last1 = -10;
  int e0, e1, e2;
  exp_t q1[$];
  exp_t q0[$];
  int log1[$];
  int log0[$];
  vec_t tbl[4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dp_feat_feeder_if #(.DW(DW)) b1 ();
  dp_feat_feeder_if #(.DW(DW)) b0 ();
  dp_feat_feeder #(.DW(DW), .NCOEF(N), .GAP(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  dp_feat_feeder #(.DW(DW), .NCOEF(N), .GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b1.dv_out === 1'b1) begin
      log1.push_back(cyc);
      chk("gap1_no_back_to_back", 32'(cyc - last1 > 1), 1);
      last1 = cyc;
      chk("gap1_busy", 32'(b1.busy), 1);
      if (q1.size() == 0) chk("gap1_unexpected_pulse", 1, 0);
      else begin
        e = q1.pop_front();
        chk("gap1_vec", b1.vec_out, e.vec);
        chk("gap1_vad", 32'(b1.vad_out), 32'(e.vad));
      end
    end
    if (b0.dv_out === 1'b1) begin
      log0.push_back(cyc);
      if (q0.size() == 0) chk("gap0_unexpected_pulse", 1, 0);
      else begin
        e = q0.pop_front();
        chk("gap0_vec", b0.vec_out, e.vec);
        chk("gap0_vad", 32'(b0.vad_out), 32'(e.vad));
      end
    end
  end

  task automatic wr(input bit sel, input logic [DW-1:0] v, input bit sof, input bit vad);
    if (sel) begin
      b1.coef_in = v; b1.coef_dv_in = 1; b1.sof_in = sof; b1.vad_in = vad;
    end else begin
      b0.coef_in = v; b0.coef_dv_in = 1; b0.sof_in = sof; b0.vad_in = vad;
    end
    @(posedge clk);
    #1;
    b1.coef_dv_in = 0; b1.sof_in = 0; b1.vad_in = 0;
    b0.coef_dv_in = 0; b0.sof_in = 0; b0.vad_in = 0;
  endtask

  task automatic frame(input bit sel, input logic [DW-1:0] base, input bit vad, input bit keep, output int e);
    for (int i = 0; i < N; i++) begin
      if (keep && sel) q1.push_back('{base + 32'(i), vad});
      if (keep && !sel) q0.push_back('{base + 32'(i), vad});
      wr(sel, base + 32'(i), i == 0, i == N - 1 ? vad : !vad);
    end
    e = cyc;
  endtask

  task automatic drain(input bit sel, input int budget);
    int k = 0;
    while (k < budget && (sel ? (q1.size() != 0 || b1.busy) : (q0.size() != 0 || b0.busy))) begin
      @(negedge clk);
      k++;
    end
    chk(sel ? "drain_gap1" : "drain_gap0", 32'(k < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    tbl[0] = '{32'd50, 1'b0, 5, 1'b0};
    tbl[1] = '{32'hFFFF_FFF8, 1'b1, 0, 1'b0};
    tbl[2] = '{32'h7FFF_FFFA, 1'b1, 11, 1'b0};
    tbl[3] = '{32'h8000_0000, 1'b0, 3, 1'b0};
    b1.coef_in = 0; b1.coef_dv_in = 0; b1.sof_in = 0; b1.vad_in = 0;
    b0.coef_in = 0; b0.coef_dv_in = 0; b0.sof_in = 0; b0.vad_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_vec", b1.vec_out, 0);
    chk("rst_dv", 32'(b1.dv_out), 0);
    chk("rst_vad", 32'(b1.vad_out), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    chk("rst_overflow", 32'(b1.overflow), 0);
    chk("rst_dv_gap0", 32'(b0.dv_out), 0);
    reset = 1;
    repeat (2) @(negedge clk);
    // single frame: latency and pulse spacing
    log1.delete();
    frame(1, 0, 1, 1, e0);
    chk("t1_overflow", 32'(b1.overflow), 0);
    drain(1, 100);
    chk("t1_pulse_count", log1.size(), N);
    for (int i = 0; i < N && i < log1.size(); i++) chk("t1_pulse_time", log1[i], e0 + 1 + 2 * i);
    // back-to-back frames fill both banks
    log1.delete();
    frame(1, 100, 0, 1, e0);
    frame(1, 200, 1, 1, e1);
    chk("b2b_overflow", 32'(b1.overflow), 0);
    drain(1, 200);
    chk("b2b_pulse_count", log1.size(), 2 * N);
    if (log1.size() > N) chk("b2b_restart", log1[N], log1[N - 1] + 4);
    // partial frames cut short by sof
    foreach (tbl[t]) begin
      for (int i = 0; i < tbl[t].partial; i++) wr(1, tbl[t].base + 32'(1000 + i), i == 0, 1);
      frame(1, tbl[t].base, tbl[t].vad, 1, e0);
      drain(1, 100);
      chk("tbl_overflow", 32'(b1.overflow), 32'(tbl[t].ovf));
    end
    // third frame while both banks are full
    log1.delete();
    frame(1, 300, 1, 1, e0);
    frame(1, 400, 0, 1, e1);
    frame(1, 500, 1, 0, e2);
    chk("ovf_set", 32'(b1.overflow), 1);
    drain(1, 300);
    chk("ovf_sticky", 32'(b1.overflow), 1);
    chk("ovf_pulse_count", log1.size(), 2 * N);
    // reset in the middle of a burst
    log1.delete();
    frame(1, 32'h10, 1, 1, e0);
    k = 0;
    while (k < 100 && log1.size() < 6) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rst_mid_reach6", 32'(log1.size()), 6);
    reset = 0;
    #1;
    chk("rst_mid_vec", b1.vec_out, 0);
    chk("rst_mid_dv", 32'(b1.dv_out), 0);
    chk("rst_mid_vad", 32'(b1.vad_out), 0);
    chk("rst_mid_busy", 32'(b1.busy), 0);
    chk("rst_mid_overflow", 32'(b1.overflow), 0);
    q1.delete();
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (40) @(negedge clk);
    chk("rst_mid_no_pulse", log1.size(), 6);
    log1.delete();
    frame(1, 32'h20, 0, 1, e0);
    drain(1, 100);
    chk("rst_after_count", log1.size(), N);
    if (log1.size() > 0) chk("rst_after_first", log1[0], e0 + 1);
    // GAP=0 instance: consecutive pulses
    log0.delete();
    frame(0, 32'hA00, 1, 1, e0);
    drain(0, 100);
    chk("gap0_pulse_count", log0.size(), N);
    for (int i = 0; i < N && i < log0.size(); i++) chk("gap0_pulse_time", log0[i], e0 + 1 + i);
    chk("scoreboard_empty", 32'(q1.size() + q0.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dp_feat_feeder.md
# dp_feat_feeder

Frame-buffering feeder that sits directly upstream of `DP_main`, the Viterbi word-detection core. It collects one feature vector of NCOEF signed coefficients per frame from the front-end, buffers it in a two-bank ping-pong store, and replays each complete vector to `DP_main`'s `vec_in`/`dv_in`/`vad_in`. Replay is a burst of single-cycle `dv_out` pulses spaced GAP+1 clocks apart, with the frame's VAD flag held alongside.

## Interface
- DW, 32, coefficient width (signed two's complement)
- NCOEF, 12, coefficients per frame
- GAP, 1, idle clocks between consecutive `dv_out` pulses (range 0..15)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- coef_in  in  DW  signed coefficient from front-end
- coef_dv_in  in  1  coef_in valid this cycle; one coefficient captured per high cycle
- sof_in  in  1  qualifies `coef_dv_in`: this coefficient is index 0 of a new frame
- vad_in  in  1  frame VAD flag, sampled with the coefficient at index NCOEF-1
- vec_out  out  DW  coefficient to `DP_main.vec_in`, held between pulses
- dv_out  out  1  one-cycle strobe to `DP_main.dv_in`
- vad_out  out  1  VAD of the frame being replayed, to `DP_main.vad_in`
- busy  out  1  high while a replay burst is in progress
- overflow  out  1  sticky: a coefficient was dropped because both banks were full

## Operation
- Storage: two banks of NCOEF×DW registers. Each bank has a `full` flag and a `vad` bit. A write pointer (bank select plus index 0..NCOEF-1) and a read pointer (bank select plus index) are kept separately.
- Write side:
  - On `coef_dv_in`, if the write bank is not full, store `coef_in` at the write index and advance the index.
  - `sof_in` with `coef_dv_in` forces index 0, discarding any partial frame in that bank.
  - On the write at index NCOEF-1, also store `vad_in`, set that bank's `full` flag, toggle the write bank, and reset the index to 0.
  - If the write bank is full, drop the coefficient and set `overflow`.
- Read FSM states:
  - IDLE → EMIT when the read bank is full.
  - EMIT: `dv_out`=1 for one cycle. Then go to GAP if GAP>0; otherwise go back to EMIT, or to DONE after the last index.
  - GAP: count GAP cycles, then go to EMIT, or to DONE if the last index has been emitted.
  - DONE (1 cycle): clear the read bank's `full` flag, toggle the read bank, go to IDLE.
- On the IDLE→EMIT edge, `vad_out` loads the bank's `vad` bit. `vec_out` loads `bank[idx]` on every EMIT entry and holds until the next entry.
- Arithmetic: none; coefficients pass through bit-exact. Index counters are `$clog2(NCOEF)` bits and never wrap beyond NCOEF-1.

## Timing
- Reset (asynchronous, active-low):
  - `vec_out`=0, `dv_out`=0, `vad_out`=0, `busy`=0, `overflow`=0.
  - Both `full` flags=0, both pointers at bank 0 / index 0, FSM=IDLE.
  - Reset mid-frame or mid-burst discards all buffered data; no further `dv_out` until a new complete frame arrives.
- Latency: last coefficient captured at edge E0 → IDLE→EMIT at edge E1 → `dv_out` high for the cycle after E1.
- Coefficient k appears with `dv_out` after edge E1+k·(GAP+1). The burst spans NCOEF·(GAP+1) clocks, plus 1 DONE cycle, plus 1 IDLE cycle before the next burst.
- `busy` is high from E1 through the DONE cycle.
- Simultaneous events:
  - A frame completing into bank B while the reader is in DONE on bank A is legal; the B burst starts 2 clocks after DONE.
  - A write into a bank during the same edge that DONE frees it is rejected (the flag clears after that edge) and sets `overflow`.
  - `sof_in` arriving mid-frame discards the partial frame without setting `overflow`.
- `dv_out` is never high on two consecutive clocks when GAP≥1.

## Test plan
- Reset, then write one frame with coefficients 0..11 and `vad_in`=1 on the last one → 12 `dv_out` pulses 2 clocks apart, first pulse 2 edges after the last write; `vec_out`=0..11 in order; `vad_out`=1; `overflow`=0.
- Write two frames back-to-back (100..111, then 200..211) → two bursts in order with no data loss; second burst starts 2 clocks after the first burst's DONE.
- Write a third frame while both banks are full → its coefficients are dropped, `overflow`=1 and stays 1; the first two frames replay intact.
- Write 5 coefficients, then `sof_in` with a full 12-coefficient frame 50..61 → exactly one burst 50..61; no `overflow`.
- Assert reset low mid-burst after the 6th pulse → outputs go to 0 immediately; no further pulses; a new frame afterwards replays normally from index 0.
- Set GAP=0 → 12 consecutive `dv_out` cycles with `vec_out` changing every clock.
